// File: rtl/oam_dma_if.sv
// Bus bundle for the OAM DMA engine: CPU register port plus the MMU-side
// master bus. The engine uses `master`; the surrounding system uses `slave`.
interface oam_dma_if;
  logic [15:0] A_cpu;
  logic [7:0]  Di_cpu;
  logic        wr_cpu;
  logic        rd_cpu;
  logic        cs_reg;
  logic [7:0]  Do_reg;
  logic [15:0] A_dma;
  logic [7:0]  Do_dma;
  logic [7:0]  Di_dma;
  logic        rd_dma;
  logic        wr_dma;
  logic        busy;

  modport master (
    input  A_cpu, Di_cpu, wr_cpu, rd_cpu, Di_dma,
    output cs_reg, Do_reg, A_dma, Do_dma, rd_dma, wr_dma, busy
  );

  modport slave (
    output A_cpu, Di_cpu, wr_cpu, rd_cpu, Di_dma,
    input  cs_reg, Do_reg, A_dma, Do_dma, rd_dma, wr_dma, busy
  );
endinterface

// File: rtl/oam_dma.sv
// Game Boy OAM DMA: a write to FF46 copies LENGTH bytes from page XX00 to
// FE00, one read/write pair every TICKS_PER_BYTE clocks.
module oam_dma #(
  parameter int unsigned TICKS_PER_BYTE = 4,
  parameter int unsigned LENGTH         = 160
) (
  input  logic       clk,
  input  logic       reset,
  oam_dma_if.master  bus
);

  localparam int unsigned         TICK_W    = $clog2(TICKS_PER_BYTE);
  localparam logic [15:0]         REG_ADDR  = 16'hFF46;
  localparam logic [15:0]         OAM_BASE  = 16'hFE00;
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICKS_PER_BYTE - 1);
  localparam logic [TICK_W-1:0]   TICK_WR   = TICK_W'(1);
  localparam logic [7:0]          IDX_LAST  = 8'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_e;

  state_e            state_q;
  logic [7:0]        page_q;
  logic [7:0]        idx_q;
  logic [TICK_W-1:0] tick_q;
  logic [7:0]        data_q;

  logic trig_c;
  logic cs_c;
  logic rd_c;
  logic wr_c;
  logic unused_rd;

  // The CPU read strobe carries no side effects for this register.
  assign unused_rd = bus.rd_cpu;

  assign cs_c   = (bus.A_cpu == REG_ADDR);
  assign trig_c = bus.wr_cpu && cs_c;
  assign rd_c   = (state_q == XFER) && (tick_q == '0);
  assign wr_c   = (state_q == XFER) && (tick_q == TICK_WR);

  // A trigger restarts from any state; an in-flight byte is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      tick_q  <= '0;
      data_q  <= 8'h00;
    end else if (trig_c) begin
      state_q <= START;
      page_q  <= bus.Di_cpu;
      idx_q   <= 8'h00;
      tick_q  <= '0;
    end else begin
      case (state_q)
        START: state_q <= XFER;
        XFER: begin
          if (rd_c) begin
            data_q <= bus.Di_dma;
          end
          if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 8'd1;
            end
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cs_reg = cs_c;
  assign bus.Do_reg = cs_c ? page_q : 8'h00;
  assign bus.rd_dma = rd_c;
  assign bus.wr_dma = wr_c;
  assign bus.Do_dma = wr_c ? data_q : 8'h00;
  assign bus.busy   = (state_q != IDLE);

  // Address bus idles at zero; destination stays inside FE00-FEFF.
  always_comb begin
    bus.A_dma = 16'h0000;
    if (rd_c) begin
      bus.A_dma = {page_q, idx_q};
    end else if (wr_c) begin
      bus.A_dma = OAM_BASE + {8'h00, idx_q};
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a timeline model of expected bus strobes
// per trigger is compared against strobes observed on the DMA bus.
module tb_oam_dma;
  localparam int unsigned T  = 4;
  localparam int unsigned L  = 160;
  localparam int unsigned T2 = 2;
  localparam int unsigned L2 = 4;
  localparam int unsigned NOCUT = 32'hFFFF_FFFF;

  typedef struct packed {
    int unsigned c;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_d = 8'h00;
  logic [7:0]  key = 8'h5A;
  int unsigned edges = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  ev_t got_q[$];
  ev_t exp_q[$];
  int unsigned busy_n = 0, busy_first = 0, busy_last = 0;

  oam_dma_if bus ();
  oam_dma_if bus2 ();

  oam_dma u_dut (.clk(clk), .reset(rst), .bus(bus));
  oam_dma #(.TICKS_PER_BYTE(T2), .LENGTH(L2)) u_small (.clk(clk), .reset(rst), .bus(bus2));

  assign bus.A_cpu   = cpu_a;
  assign bus.Di_cpu  = cpu_d;
  assign bus.wr_cpu  = cpu_wr & ~sel;
  assign bus.rd_cpu  = 1'b0;
  assign bus.Di_dma  = bus.A_dma[7:0] ^ key;
  assign bus2.A_cpu  = cpu_a;
  assign bus2.Di_cpu = cpu_d;
  assign bus2.wr_cpu = cpu_wr & sel;
  assign bus2.rd_cpu = 1'b0;
  assign bus2.Di_dma = bus2.A_dma[7:0] ^ key;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at edge %0d", edges);
    $fatal(1, "watchdog");
  end

  logic        m_rd, m_wr, m_busy;
  logic [15:0] m_a;
  logic [7:0]  m_do;
  always_comb begin
    m_rd   = sel ? bus2.rd_dma : bus.rd_dma;
    m_wr   = sel ? bus2.wr_dma : bus.wr_dma;
    m_busy = sel ? bus2.busy   : bus.busy;
    m_a    = sel ? bus2.A_dma  : bus.A_dma;
    m_do   = sel ? bus2.Do_dma : bus.Do_dma;
  end

  // Strobe recorder: cycle c is the clock period that ends at edge c.
  always @(negedge clk) begin
    if (m_rd) got_q.push_back(ev_t'{edges + 1, 1'b0, m_a, m_do});
    if (m_wr) got_q.push_back(ev_t'{edges + 1, 1'b1, m_a, m_do});
    if (m_busy === 1'b1) begin
      if (busy_n == 0) busy_first = edges + 1;
      busy_last = edges + 1;
      busy_n++;
    end
  end

  logic p_rd0 = 1'b0, p_wr0 = 1'b0, p_rd1 = 1'b0, p_wr1 = 1'b0;
  always @(negedge clk) begin
    if (edges >= 2) begin
      checks++;
      if ((bus.rd_dma & bus.wr_dma) || (!bus.wr_dma && bus.Do_dma !== 8'h00) ||
          (!bus.rd_dma && !bus.wr_dma && bus.A_dma !== 16'h0000) ||
          (bus.rd_dma && p_rd0) || (bus.wr_dma && p_wr0)) begin
        failures++;
        $display("FAIL invariant dut0 edge=%0d rd=%b wr=%b a=%h do=%h prev_rd=%b prev_wr=%b",
                 edges, bus.rd_dma, bus.wr_dma, bus.A_dma, bus.Do_dma, p_rd0, p_wr0);
      end
      checks++;
      if ((bus2.rd_dma & bus2.wr_dma) || (!bus2.wr_dma && bus2.Do_dma !== 8'h00) ||
          (!bus2.rd_dma && !bus2.wr_dma && bus2.A_dma !== 16'h0000) ||
          (bus2.rd_dma && p_rd1) || (bus2.wr_dma && p_wr1)) begin
        failures++;
        $display("FAIL invariant dut1 edge=%0d rd=%b wr=%b a=%h do=%h prev_rd=%b prev_wr=%b",
                 edges, bus2.rd_dma, bus2.wr_dma, bus2.A_dma, bus2.Do_dma, p_rd1, p_wr1);
      end
    end
    p_rd0 = bus.rd_dma; p_wr0 = bus.wr_dma;
    p_rd1 = bus2.rd_dma; p_wr1 = bus2.wr_dma;
  end

  // Reference timeline for a transfer triggered at edge n, truncated after cycle cut.
  task automatic model_xfer(input int unsigned n, input logic [7:0] pg, input logic [7:0] kk,
                            input int unsigned t, input int unsigned l, input int unsigned cut);
    for (int unsigned k = 0; k < l; k++) begin
      int unsigned cr;
      cr = n + 2 + k * t;
      if (cr <= cut) exp_q.push_back(ev_t'{cr, 1'b0, {pg, 8'(k)}, 8'h00});
      if (cr + 1 <= cut) exp_q.push_back(ev_t'{cr + 1, 1'b1, 16'hFE00 + 16'(k), 8'(k) ^ kk});
    end
  endtask

  task automatic clear_obs();
    got_q.delete(); exp_q.delete(); busy_n = 0; busy_first = 0; busy_last = 0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int unsigned n);
    cpu_a = a; cpu_d = d; cpu_wr = 1'b1; n = edges + 1;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_a = 16'h0000;
  endtask

  task automatic wait_to(input int unsigned e);
    while (edges + 1 < e) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    cpu_a = 16'hFF46; #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.rd_dma !== 1'b0 || bus.wr_dma !== 1'b0 ||
        bus.A_dma !== 16'h0000 || bus.Do_dma !== 8'h00) begin
      failures++;
      $display("FAIL reset_idle busy=%b rd=%b wr=%b a=%h do=%h required all zero",
               bus.busy, bus.rd_dma, bus.wr_dma, bus.A_dma, bus.Do_dma);
    end
    checks++;
    if (bus.cs_reg !== 1'b1 || bus.Do_reg !== 8'h00) begin
      failures++;
      $display("FAIL reset_reg cs=%b do_reg=%h required cs=1 do_reg=00", bus.cs_reg, bus.Do_reg);
    end
    checks++;
    if (bus2.busy !== 1'b0 || bus2.Do_reg !== 8'h00 || bus2.A_dma !== 16'h0000) begin
      failures++;
      $display("FAIL reset_small busy=%b do_reg=%h a=%h required 0/00/0000",
               bus2.busy, bus2.Do_reg, bus2.A_dma);
    end
    cpu_a = 16'hFF47; #1;
    checks++;
    if (bus.cs_reg !== 1'b0 || bus.Do_reg !== 8'h00) begin
      failures++;
      $display("FAIL reset_other_addr cs=%b do_reg=%h required 0/00", bus.cs_reg, bus.Do_reg);
    end
    cpu_a = 16'h0000;
  endtask

  task automatic test_transfer();
    int unsigned n;
    clear_obs(); key = 8'h5A;
    cpu_write(16'hFF46, 8'hC1, n);
    model_xfer(n, 8'hC1, key, T, L, NOCUT);
    wait_to(n + L * T + 12);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL transfer_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL transfer_ev[%0d] got c=%0d wr=%b a=%h d=%h required c=%0d wr=%b a=%h d=%h", i,
                 got_q[i].c, got_q[i].wr, got_q[i].a, got_q[i].d, exp_q[i].c, exp_q[i].wr, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++;
    if (busy_first != n + 1 || busy_last != n + 1 + L * T || busy_n != L * T + 1) begin
      failures++;
      $display("FAIL transfer_busy got first=%0d last=%0d n=%0d required %0d/%0d/%0d",
               busy_first, busy_last, busy_n, n + 1, n + 1 + L * T, L * T + 1);
    end
    cpu_a = 16'hFF46; #1;
    checks++;
    if (bus.Do_reg !== 8'hC1) begin
      failures++;
      $display("FAIL transfer_readback got=%h required=c1", bus.Do_reg);
    end
    cpu_a = 16'h0000;
  endtask

  task automatic test_retrigger(input logic [7:0] p1, input logic [7:0] p2, input int unsigned off,
                                input logic [7:0] kk);
    int unsigned n, m;
    clear_obs(); key = kk;
    cpu_write(16'hFF46, p1, n);
    wait_to(n + off);
    cpu_write(16'hFF46, p2, m);
    model_xfer(n, p1, kk, T, L, m);
    model_xfer(m, p2, kk, T, L, NOCUT);
    wait_to(m + L * T + 12);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL retrigger_count off=%0d got=%0d required=%0d", off, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL retrigger_ev[%0d] got c=%0d wr=%b a=%h d=%h required c=%0d wr=%b a=%h d=%h", i,
                 got_q[i].c, got_q[i].wr, got_q[i].a, got_q[i].d, exp_q[i].c, exp_q[i].wr, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++;
    if (busy_first != n + 1 || busy_last != m + 1 + L * T || busy_n != m + 1 + L * T - n) begin
      failures++;
      $display("FAIL retrigger_busy off=%0d got first=%0d last=%0d n=%0d required %0d/%0d/%0d", off,
               busy_first, busy_last, busy_n, n + 1, m + 1 + L * T, m + 1 + L * T - n);
    end
  endtask

  task automatic test_back_to_back();
    // Second trigger lands on the last tick of the final byte.
    test_retrigger(8'($urandom), 8'($urandom), L * T + 1, 8'($urandom));
  endtask

  task automatic test_reset_mid();
    int unsigned n, r;
    clear_obs(); key = 8'h5A;
    cpu_write(16'hFF46, 8'hC1, n);
    wait_to(n + 200);
    rst = 1'b1; r = edges + 1;
    @(negedge clk); rst = 1'b0;
    model_xfer(n, 8'hC1, key, T, L, r);
    wait_to(r + 20);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL reset_mid_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_mid_ev[%0d] got c=%0d wr=%b a=%h d=%h required c=%0d wr=%b a=%h d=%h", i,
                 got_q[i].c, got_q[i].wr, got_q[i].a, got_q[i].d, exp_q[i].c, exp_q[i].wr, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++;
    if (busy_first != n + 1 || busy_last != r || busy_n != r - n) begin
      failures++;
      $display("FAIL reset_mid_busy got first=%0d last=%0d n=%0d required %0d/%0d/%0d",
               busy_first, busy_last, busy_n, n + 1, r, r - n);
    end
    // Reset and trigger on the same edge: reset must win.
    clear_obs();
    rst = 1'b1; cpu_a = 16'hFF46; cpu_d = 8'hAA; cpu_wr = 1'b1;
    @(negedge clk); rst = 1'b0; cpu_wr = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (bus.Do_reg !== 8'h00 || got_q.size() != 0 || busy_n != 0) begin
      failures++;
      $display("FAIL reset_with_trigger do_reg=%h strobes=%0d busy_cycles=%0d required 00/0/0",
               bus.Do_reg, got_q.size(), busy_n);
    end
    cpu_a = 16'h0000;
    clear_obs();
    cpu_write(16'hFF46, 8'h80, n);
    model_xfer(n, 8'h80, key, T, L, NOCUT);
    wait_to(n + L * T + 12);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL after_reset_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL after_reset_ev[%0d] got c=%0d wr=%b a=%h d=%h required c=%0d wr=%b a=%h d=%h", i,
                 got_q[i].c, got_q[i].wr, got_q[i].a, got_q[i].d, exp_q[i].c, exp_q[i].wr, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_other_writes();
    int unsigned n;
    logic [15:0] near [4];
    near[0] = 16'hFF45; near[1] = 16'hFF47; near[2] = 16'h7F46; near[3] = 16'hFE46;
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      a = (i < 4) ? near[i] : 16'($urandom);
      if (a == 16'hFF46) a = 16'hFF44;
      cpu_write(a, 8'($urandom), n);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() != 0 || busy_n != 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL other_writes strobes=%0d busy_cycles=%0d busy=%b required 0/0/0",
               got_q.size(), busy_n, bus.busy);
    end
    cpu_a = 16'hFF46; #1;
    checks++;
    if (bus.Do_reg !== 8'h80) begin
      failures++;
      $display("FAIL other_writes_page got=%h required=80", bus.Do_reg);
    end
    cpu_a = 16'h0000;
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      test_retrigger(8'($urandom), 8'($urandom), $urandom_range(2, L * T), 8'($urandom));
    end
  endtask

  task automatic test_param();
    int unsigned n;
    sel = 1'b1;
    @(negedge clk);
    clear_obs(); key = 8'($urandom);
    cpu_write(16'hFF46, 8'hFF, n);
    model_xfer(n, 8'hFF, key, T2, L2, NOCUT);
    wait_to(n + L2 * T2 + 10);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL param_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL param_ev[%0d] got c=%0d wr=%b a=%h d=%h required c=%0d wr=%b a=%h d=%h", i,
                 got_q[i].c, got_q[i].wr, got_q[i].a, got_q[i].d, exp_q[i].c, exp_q[i].wr, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++;
    if (busy_first != n + 1 || busy_last != n + 9 || busy_n != 9) begin
      failures++;
      $display("FAIL param_busy got first=%0d last=%0d n=%0d required %0d/%0d/9",
               busy_first, busy_last, busy_n, n + 1, n + 9);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_transfer();
    test_retrigger(8'hC1, 8'hD0, 50, 8'h5A);
    test_back_to_back();
    test_reset_mid();
    test_other_writes();
    test_random();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
